// File: rtl/dispatch_source.sv
// Host-to-network input dispatcher: rebuilds one spike vector per frame from a
// stream of a count word followed by that many input indices.
module dispatch_source #(
    parameter int NUM_INP   = 8,
    parameter int SRC_WIDTH = $clog2(NUM_INP + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [SRC_WIDTH-1:0] src,
    output logic                 net_valid,
    input  logic                 net_ready,
    output logic [NUM_INP-1:0]   net_inp,
    output logic                 err
);

    localparam int CNT_W = $clog2(NUM_INP + 1);
    localparam logic [SRC_WIDTH-1:0] NUM_INP_W = SRC_WIDTH'(NUM_INP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             src_acc;

    // One-hot decode of an index already known to be below NUM_INP.
    function automatic logic [NUM_INP-1:0] onehot(input logic [SRC_WIDTH-1:0] idx);
        logic [NUM_INP-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_INP; k++) begin
            if (idx == SRC_WIDTH'(k)) begin
                v[k] = 1'b1;
            end
        end
        return v;
    endfunction

    // Handshake flags decode state only; rst masks src_ready while asserted.
    assign src_ready = !rst && (state != SEND);
    assign net_valid = (state == SEND);
    assign src_acc   = src_valid && src_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            net_inp   <= '0;
            remaining <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (src_acc) begin
                        if (src == '0) begin
                            net_inp <= '0;
                            state   <= SEND;
                        end else if (src <= NUM_INP_W) begin
                            remaining <= CNT_W'(src);
                            state     <= RECV;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (src_acc) begin
                        // Out-of-range indices still consume a slot of the frame.
                        remaining <= remaining - CNT_W'(1);
                        if (src < NUM_INP_W) begin
                            net_inp <= net_inp | onehot(src);
                        end else begin
                            err <= 1'b1;
                        end
                        if (remaining == CNT_W'(1)) begin
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (net_ready) begin
                        net_inp <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dispatch_source.md
Name: dispatch_source

Overview:
- Host-to-network input dispatcher; the inverse of the network output sink.
- Consumes a stream of SRC_WIDTH-bit words and rebuilds one NUM_INP-bit spike vector per frame.
- Frame format: a count word N, then N input indices. Indices may arrive in any order.
- Presents the completed vector to the network with a valid/ready handshake. Sits between the host link deserializer and the network input port.

Parameters:
- NUM_INP, default 8: number of network inputs (width of net_inp).
- SRC_WIDTH, default $clog2(NUM_INP + 1): width of each stream word. It must hold both a count of 0..NUM_INP and an index of 0..NUM_INP-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- src_valid  input  1  upstream word valid.
- src_ready  output  1  block can accept a word.
- src  input  SRC_WIDTH  stream word (count or index).
- net_valid  output  1  net_inp holds a complete frame.
- net_ready  input  1  network accepts the frame.
- net_inp  output  NUM_INP  spike vector; bit k set means input k fires.
- err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (rst high at a clock edge):
  - state goes to IDLE; net_inp, remaining-count register and err go to 0; net_valid goes to 0.
  - src_ready is 0 while rst is high. Reset has priority over every other event.
- A word is accepted when src_valid && src_ready are both high. A frame is delivered when net_valid && net_ready are both high.
- IDLE (src_ready = 1, net_valid = 0), on accepting word w:
  - w == 0: go to SEND with net_inp = 0.
  - 1 <= w <= NUM_INP: remaining <= w; go to RECV.
  - w > NUM_INP: pulse err; stay in IDLE; the word is discarded.
- RECV (src_ready = 1, net_valid = 0), on accepting index x:
  - remaining <= remaining - 1.
  - If x < NUM_INP: net_inp[x] <= 1. Duplicate indices simply OR in; no error.
  - If x >= NUM_INP: pulse err; the bit is ignored, but the word still counts toward remaining.
  - When remaining == 1 at acceptance, go to SEND.
- SEND (src_ready = 0, net_valid = 1):
  - net_inp is held stable.
  - On net_ready: go to IDLE and clear net_inp to 0 in the same edge.
  - No stream word is accepted in SEND, so there is no simultaneous src/net handshake.
- Latency:
  - net_valid rises on the cycle after the final index (or a zero count) is accepted.
  - Minimum frame period is N + 2 cycles: N+1 word cycles plus one SEND cycle with net_ready already high.
- src_ready and net_valid are pure decodes of state; there is no combinational path from src_valid or net_ready.
- Idle cycles (src_valid low) inside RECV are allowed indefinitely; partial state is retained.
- Arithmetic:
  - remaining is $clog2(NUM_INP + 1) bits wide, unsigned, and never wraps.
  - Index compare against NUM_INP is unsigned at SRC_WIDTH bits.
- err is registered, high for exactly one cycle per offending word, and does not stall the stream.
- Reset mid-frame (RECV or SEND) discards the partial or pending frame; no net_valid is produced for it.

Test Plan (NUM_INP = 8, SRC_WIDTH = 4):
- Words 3,1,4,6 with src_valid held high and net_ready high -> net_valid for one cycle starting the cycle after word 6; net_inp = 8'b0101_0010; src_ready high again the next cycle.
- Word 0 -> next cycle net_valid = 1, net_inp = 8'h00; back to IDLE after the handshake.
- Frame 2,5,0 with net_ready low for 5 cycles -> net_inp = 8'h21 held stable and src_ready = 0 throughout; a following word 1 stalls until the handshake completes.
- Frame 3,2,9,2 -> err pulses on the cycle after word 9; the frame still completes after the 4th word with net_inp = 8'h04 (duplicate 2 merges).
- Word 9 -> err pulse, no net_valid, src_ready stays 1; a following frame 1,0 -> net_inp = 8'h01.
- Words 3,2, then rst high for one cycle -> net_valid stays 0 and src_ready = 0 during reset; a following frame 1,7 -> net_inp = 8'h80 with no trace of bit 2.
